// File: rtl/rising_edge_detector.sv
// Rising-edge detector: turns each 0->1 transition of a level input into a
// single-cycle tick, with an optional input synchronizer chain.
module rising_edge_detector #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic tck
);

  typedef enum logic [1:0] {
    ST_ZERO = 2'b00,
    ST_EDGE = 2'b01,
    ST_ONE  = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  logic   s_c;
  state_e state_q, state_d;
  logic   tck_q, tck_d;

  if (SYNC_STAGES > 3) begin : g_bad_param
    $error("rising_edge_detector: SYNC_STAGES must be 0..3");
  end

  // Input sampling: either direct or through a reset-to-zero flop chain
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_c = lvl;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d    = '0;
      sync_d[0] = lvl;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign s_c = sync_q[SYNC_STAGES-1];
  end

  // Next-state logic; the unused code falls back to ZERO
  always_comb begin
    state_d = ST_ZERO;
    tck_d   = 1'b0;
    case (state_q)
      ST_ZERO:         state_d = s_c ? ST_EDGE : ST_ZERO;
      ST_EDGE, ST_ONE: state_d = s_c ? ST_ONE  : ST_ZERO;
      default:         state_d = ST_ZERO;
    endcase
    // Tick flop mirrors the EDGE state so the output never depends on lvl combinationally
    tck_d = (state_d == ST_EDGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ZERO;
      tck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tck_q   <= tck_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: tb/tb_rising_edge_detector.sv
// Scoreboard bench for rising_edge_detector: SYNC_STAGES=0 and SYNC_STAGES=2
// instances driven by the same directed lvl vectors.
module tb_rising_edge_detector;

  logic clk = 1'b0;
  logic rst;
  logic lvl;
  logic tck0, tck2;

  typedef struct {
    logic  e0;
    logic  e2;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #25 clk = ~clk;

  rising_edge_detector #(.SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .rst(rst), .lvl(lvl), .tck(tck0)
  );

  rising_edge_detector #(.SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .lvl(lvl), .tck(tck2)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one lvl sample mid-cycle and queue the tick expected after the next edge
  task automatic step(input logic l, input logic e0, input logic e2, input string tag);
    exp_t x;
    @(negedge clk);
    lvl   = l;
    x.e0  = e0;
    x.e2  = e2;
    x.tag = tag;
    sb_q.push_back(x);
  endtask

  task automatic run_vec(input logic [31:0] lv, input logic [31:0] e0v,
                         input logic [31:0] e2v, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(lv[n-1-i], e0v[n-1-i], e2v[n-1-i], $sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #10;
    rst = 1'b0;
    lvl = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_tck0"}, tck0, 1'b0);
    chk({tag, "_rst_tck2"}, tck2, 1'b0);
    @(posedge clk);
    #10;
    rst = 1'b1;
  endtask

  // Monitor: compare both outputs shortly after every active edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #5;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk({x.tag, "_tck0"}, tck0, x.e0);
        chk({x.tag, "_tck2"}, tck2, x.e2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    lvl = 1'b1;
    #1;
    chk("por_async_tck0", tck0, 1'b0);
    chk("por_async_tck2", tck2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("por_held_tck0[%0d]", i), tck0, 1'b0);
      chk($sformatf("por_held_tck2[%0d]", i), tck2, 1'b0);
    end
    lvl = 1'b0;
    @(posedge clk);
    #10;
    rst = 1'b1;

    // 0100111101111100 plus two trailing lows so the 2-stage ticks drain
    run_vec(32'(18'b0100111101111100_00), 32'(18'b0100100001000000_00),
            32'(18'b00_0100100001000000), 18, "pattern");

    do_reset("held");
    run_vec(32'(22'h3FFFFF), 32'(22'h200000), 32'(22'h080000), 22, "held");

    do_reset("pulse");
    run_vec(32'(9'b010101000), 32'(9'b010101000), 32'(9'b000101010), 9, "pulse");

    // Reset while the tick is high, then release with lvl already high
    do_reset("midtick");
    step(1'b0, 1'b0, 1'b0, "midtick_pre0");
    step(1'b1, 1'b1, 1'b0, "midtick_pre1");
    @(posedge clk);
    #10;
    rst = 1'b0;
    #1;
    chk("midtick_async_tck0", tck0, 1'b0);
    chk("midtick_async_tck2", tck2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midtick_held_tck0[%0d]", i), tck0, 1'b0);
      chk($sformatf("midtick_held_tck2[%0d]", i), tck2, 1'b0);
    end
    @(posedge clk);
    #10;
    rst = 1'b1;
    run_vec(32'(5'b11110), 32'(5'b10000), 32'(5'b00100), 5, "release_high");

    @(posedge clk);
    #10;
    chk("scoreboard_drained", 1'(sb_q.size() == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rising_edge_detector.md
Name: rising_edge_detector

Overview:
Synchronous Moore-type rising-edge detector. Converts a level input `lvl` into a single-clock-cycle tick `tck` each time `lvl` goes from 0 to 1. Used as a front end for push-button or level controls, e.g. the "start" input of the sequential signed multiplier. Optional input synchronizer stages allow use with asynchronous inputs.

Parameters:
- SYNC_STAGES, 0: number of flip-flops in front of the FSM on `lvl`.
  - 0 means `lvl` is used directly.
  - Legal range is 0..3.
  - Each stage adds one cycle of latency.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- lvl  input  1  level input to be monitored.
- tck  output 1  one-cycle tick on each detected 0->1 transition of `lvl`.

Behaviour:
- One clock domain (`clk`). Reset is asynchronous and active-low on `rst`.
- Sampled input `s`:
  - With SYNC_STAGES=0, `s` = `lvl` sampled at the `clk` rising edge.
  - Otherwise `s` is the output of the last synchronizer flip-flop.
  - Synchronizer flops reset to 0.
- Three-state Moore FSM (2-bit encoding):
  - ZERO (00): input low. `tck`=0.
  - EDGE (01): rising edge just seen. `tck`=1.
  - ONE (10): input held high. `tck`=0.
  - Code 11 is unused and must recover to ZERO on the next clock edge; `tck`=0 in it.
- Transitions, evaluated at each `clk` rising edge:
  - ZERO: `s`=1 -> EDGE; `s`=0 -> ZERO.
  - EDGE: `s`=1 -> ONE; `s`=0 -> ZERO.
  - ONE: `s`=1 -> ONE; `s`=0 -> ZERO.
- Output:
  - `tck` is decoded from the state register only, with no combinational path from `lvl`.
  - It is glitch-free and registered-state driven.
- Latency (SYNC_STAGES=0): `lvl` high at rising edge k, with the FSM in ZERO, puts `tck`=1 from edge k to edge k+1.
  - It then drops regardless of `lvl`.
  - Each synchronizer stage adds one cycle.
- Pulse width is exactly one clock cycle, even if `lvl` stays high indefinitely.
- Re-arming: `lvl` must be sampled low at least once (FSM in ZERO) before another tick can be produced.
- A `lvl` high pulse lasting exactly one cycle produces exactly one tick. The path is ZERO->EDGE->ZERO.
- A low glitch between two clock edges that is never sampled produces no tick.
- Reset (`rst`=0):
  - Immediately, without waiting for a clock, the state becomes ZERO, `tck` becomes 0 and the synchronizer flops become 0.
  - State is held while `rst`=0.
  - Reset asserted during EDGE truncates the tick immediately.
- Release of reset with `lvl` already high:
  - The first sampled high counts as a rising edge.
  - One tick is produced after the synchronizer latency.
- X/undefined `lvl` is not required to be handled.

Test Plan:
- Reset: `rst`=0 with `lvl`=1 and toggling `clk` -> `tck`=0 throughout, and the FSM is in ZERO asynchronously, before any clock edge.
- Pattern (SYNC_STAGES=0, period 50, `lvl` changing mid-cycle): apply 0100111101111100 one bit per cycle after reset release.
  - Expected: exactly three one-cycle ticks, at the cycles following the samples of bits 1, 4 and 9.
  - `tck`=0 everywhere else.
- Held high: `lvl` held at 1 for 20 cycles -> single `tck` pulse in the first cycle only, then 0 for 19 cycles.
- Single-cycle pulse: `lvl` high for exactly one sample, then low -> one tick. Repeat with pulses two cycles apart -> one tick per pulse.
- Async reset mid-tick: assert `rst`=0 while `tck`=1 -> `tck` drops to 0 immediately.
  - Release with `lvl`=1 -> one tick on the next cycle.
- SYNC_STAGES=2: repeat the pattern test -> identical tick sequence, delayed by exactly two cycles.
